// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by both the APB master and the register completer.
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB completer bus bundle between the interconnect select line
// and one apb_slave_regs instance.
interface apb_slave_regs_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              sel_in;
  logic              en_in;
  logic              wr_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              slverr;

  modport master (
    output sel_in,
    output en_in,
    output wr_in,
    output addr_in,
    output data_in,
    input  ready,
    input  data_out,
    input  slverr
  );

  modport slave (
    input  sel_in,
    input  en_in,
    input  wr_in,
    input  addr_in,
    input  data_in,
    output ready,
    output data_out,
    output slverr
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// Register storage: one synchronous write port, one asynchronous
// read port, async active-low clear of every entry.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_W   = APB_DATA_W,
  parameter int NUM_REGS = 16,
  localparam int IW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_regs.sv
// APB register-bank completer: setup latch, window decode, FSM.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES before ready.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int              ADDR_W      = APB_ADDR_W,
  parameter int              DATA_W      = APB_DATA_W,
  parameter int              NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h300,
  parameter int              WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  apb_slave_regs_if.slave  bus
);

  localparam int IW = $clog2(NUM_REGS);

  if (NUM_REGS < 2 || NUM_REGS > 256 ||
      (1 << IW) != NUM_REGS) begin : g_bad_regs
    $error("NUM_REGS must be a power of two in 2..256");
  end
  if (WAIT_CYCLES < 0) begin : g_bad_wait
    $error("WAIT_CYCLES must be non-negative");
  end

  apb_state_t state, state_d;

  logic              valid_q;
  logic              wr_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] off;
  logic              dec_ok;
  logic [IW-1:0]     dec_idx;
  logic [DATA_W-1:0] rf_rdata;
  logic              setup;
  logic              cnt_zero;
  logic              ready;
  logic              we;

  // Offset wraps below base; the >= check rejects those.
  assign off     = bus.addr_in - BASE_ADDR;
  assign dec_idx = off[IW+1:2];
  assign dec_ok  = (bus.addr_in[1:0] == 2'b00) &&
                   (bus.addr_in >= BASE_ADDR) &&
                   ((off >> 2) < ADDR_W'(NUM_REGS));

  assign setup = (state == IDLE) && bus.sel_in &&
                 !bus.en_in;

`ifdef APB_SLAVE_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 0) ?
                      $clog2(WAIT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (setup) begin
      cnt <= CW'(WAIT_CYCLES);
    end else if (state == ACCESS && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);
`else
  assign cnt_zero = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    ready   = 1'b0;
    unique case (state)
      IDLE: begin
        if (setup) state_d = ACCESS;
      end
      ACCESS: begin
        ready = cnt_zero & bus.sel_in & bus.en_in;
        // Dropped select aborts silently.
        if (!bus.sel_in || ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (setup) begin
      valid_q <= dec_ok;
      wr_q    <= bus.wr_in;
      idx_q   <= dec_idx;
      wdata_q <= bus.data_in;
      rdata_q <= dec_ok ? rf_rdata : '0;
    end
  end

  assign we = ready & valid_q & wr_q;

  apb_slave_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (dec_idx),
    .rdata (rf_rdata)
  );

  assign bus.ready    = ready;
  assign bus.slverr   = ready & ~valid_q;
  assign bus.data_out = rdata_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed self-checking bench for apb_slave_regs.
// Latency expectations follow APB_SLAVE_WAIT_EN.
module tb_apb_slave_regs;

`ifdef APB_SLAVE_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  apb_slave_regs_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  apb_slave_regs #(
    .ADDR_W      (12),
    .DATA_W      (32),
    .NUM_REGS    (16),
    .BASE_ADDR   (12'h300),
    .WAIT_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One transfer; leaves sel/en high so another can follow at once.
  task automatic xfer(
    input  logic        w,
    input  logic [11:0] a,
    input  logic [31:0] d,
    output logic [31:0] rd,
    output logic        err,
    output int          cyc
  );
    rd  = '0;
    err = 1'b0;
    cyc = -1;
    bus.sel_in  = 1'b1;
    bus.en_in   = 1'b0;
    bus.wr_in   = w;
    bus.addr_in = a;
    bus.data_in = d;
    @(posedge clk); #1;
    bus.en_in   = 1'b1;
    bus.addr_in = a ^ 12'h004;
    bus.data_in = ~d;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        rd  = bus.data_out;
        err = bus.slverr;
        cyc = i;
        break;
      end
      @(posedge clk); #1;
    end
    if (cyc < 0) begin
      asserts++;
      fails++;
      $display("FAIL xfer_timeout addr=%h got no ready, required ready within 16 cycles", a);
      bus.sel_in = 1'b0;
      bus.en_in  = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    bus.sel_in = 1'b0;
    bus.en_in  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        err;
    int          cyc;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    asserts++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got=%b exp=0", bus.ready);
    end
    asserts++;
    if (bus.slverr !== 1'b0) begin
      fails++;
      $display("FAIL reset_slverr got=%b exp=0", bus.slverr);
    end
    asserts++;
    if (bus.data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got=%h exp=0", bus.data_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 12'h300, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_read300 got=%h/%b exp=0/0", rd, err);
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        err;
    int          cyc;
    xfer(1'b1, 12'h300, 32'd13, rd, err, cyc);
    asserts++;
    if (err !== 1'b0 || cyc != LAT) begin
      fails++;
      $display("FAIL wr300 got err=%b cyc=%0d exp 0/%0d", err, cyc, LAT);
    end
    #1;
    asserts++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_one_cycle got=%b exp=0", bus.ready);
    end
    idle();
    xfer(1'b0, 12'h300, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'd13 || err !== 1'b0 || cyc != LAT) begin
      fails++;
      $display("FAIL rd300 got=%h/%b/%0d exp=d/0/%0d", rd, err, cyc, LAT);
    end
    idle();
  endtask

  task automatic test_wait();
    logic [31:0] rd;
    logic        err;
    int          cyc;
    xfer(1'b1, 12'h33C, 32'hDEADBEEF, rd, err, cyc);
    asserts++;
    if (err !== 1'b0 || cyc != LAT) begin
      fails++;
      $display("FAIL wr33c got err=%b cyc=%0d exp 0/%0d", err, cyc, LAT);
    end
    idle();
    xfer(1'b0, 12'h33C, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      fails++;
      $display("FAIL rd33c got=%h/%b exp=deadbeef/0", rd, err);
    end
    idle();
  endtask

  task automatic test_errors();
    logic [11:0] bad [3];
    logic [31:0] rd;
    logic        err;
    int          cyc;
    bad[0] = 12'h340;
    bad[1] = 12'h302;
    bad[2] = 12'h2FC;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, bad[i], 32'hBAD00000 | i, rd, err, cyc);
      asserts++;
      if (err !== 1'b1 || cyc != LAT) begin
        fails++;
        $display("FAIL err_wr %h got err=%b cyc=%0d exp 1/%0d", bad[i], err, cyc, LAT);
      end
      idle();
      xfer(1'b0, bad[i], 32'h0, rd, err, cyc);
      asserts++;
      if (rd !== 32'h0 || err !== 1'b1) begin
        fails++;
        $display("FAIL err_rd %h got=%h/%b exp=0/1", bad[i], rd, err);
      end
      idle();
    end
    xfer(1'b0, 12'h300, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'd13) begin
      fails++;
      $display("FAIL err_keep300 got=%h exp=d", rd);
    end
    idle();
    xfer(1'b0, 12'h33C, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL err_keep33c got=%h exp=deadbeef", rd);
    end
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        err;
    int          cyc;
    bus.sel_in  = 1'b1;
    bus.en_in   = 1'b0;
    bus.wr_in   = 1'b1;
    bus.addr_in = 12'h304;
    bus.data_in = 32'd5;
    @(posedge clk); #1;
    bus.en_in = (LAT > 1);
    @(negedge clk);
    asserts++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_acc1 got=%b exp=0", bus.ready);
    end
    @(posedge clk); #1;
    bus.sel_in = 1'b0;
    bus.en_in  = 1'b0;
    @(negedge clk);
    asserts++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_drop got=%b exp=0", bus.ready);
    end
    @(posedge clk); #1;
    xfer(1'b0, 12'h304, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL abort_rd304 got=%h/%b exp=0/0", rd, err);
    end
    idle();
    bus.sel_in  = 1'b1;
    bus.en_in   = 1'b1;
    bus.wr_in   = 1'b1;
    bus.addr_in = 12'h304;
    bus.data_in = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      asserts++;
      if (bus.ready !== 1'b0) begin
        fails++;
        $display("FAIL nosetup_%0d got=%b exp=0", i, bus.ready);
      end
      @(posedge clk); #1;
    end
    idle();
    xfer(1'b0, 12'h304, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'h0) begin
      fails++;
      $display("FAIL nosetup_rd304 got=%h exp=0", rd);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        err;
    int          cyc;
    logic [11:0] wa [3];
    logic [11:0] ra [3];
    logic [31:0] rx [3];
    wa[0] = 12'h308; wa[1] = 12'h30C; wa[2] = 12'h310;
    ra[0] = 12'h310; ra[1] = 12'h30C; ra[2] = 12'h308;
    rx[0] = 32'd3;   rx[1] = 32'd2;   rx[2] = 32'd1;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, wa[i], 32'(i + 1), rd, err, cyc);
      asserts++;
      if (err !== 1'b0 || cyc != LAT) begin
        fails++;
        $display("FAIL b2b_wr %h got err=%b cyc=%0d exp 0/%0d", wa[i], err, cyc, LAT);
      end
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, ra[i], 32'h0, rd, err, cyc);
      asserts++;
      if (rd !== rx[i] || cyc != LAT) begin
        fails++;
        $display("FAIL b2b_rd %h got=%h cyc=%0d exp=%h/%0d", ra[i], rd, cyc, rx[i], LAT);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        err;
    int          cyc;
    bus.sel_in  = 1'b1;
    bus.en_in   = 1'b0;
    bus.wr_in   = 1'b1;
    bus.addr_in = 12'h310;
    bus.data_in = 32'h55;
    @(posedge clk); #1;
    bus.en_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    asserts++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_ready got=%b exp=0", bus.ready);
    end
    bus.sel_in = 1'b0;
    bus.en_in  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 12'h310, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_rd310 got=%h exp=0", rd);
    end
    idle();
    xfer(1'b0, 12'h300, 32'h0, rd, err, cyc);
    asserts++;
    if (rd !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_rd300 got=%h exp=0", rd);
    end
    idle();
  endtask

  initial begin
    bus.sel_in  = 1'b0;
    bus.en_in   = 1'b0;
    bus.wr_in   = 1'b0;
    bus.addr_in = '0;
    bus.data_in = '0;
    test_reset();
    test_write_read();
    test_wait();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, required end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_slave_regs.md
# apb_slave_regs

APB completer that terminates the bus driven by `apb_master` and exposes a bank of 32-bit read/write registers. Decodes a word-aligned window starting at `BASE_ADDR`, answers with `ready` after an optional wait-state count, and flags out-of-window or misaligned accesses with `slverr`. One instance sits on each peripheral select line of the APB interconnect.

## Interface
Parameters:
- `ADDR_W`, 12: address width.
- `DATA_W`, 32: data width.
- `NUM_REGS`, 16: number of registers; power of two, 2..256.
- `BASE_ADDR`, 12'h300: byte address of register 0.
- `WAIT_CYCLES`, 2: extra ACCESS cycles before `ready`; used only with `APB_SLAVE_WAIT_EN`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `sel_in`  in  1  PSEL from the master (`sel_port` decode).
- `en_in`  in  1  PENABLE (master `en`).
- `wr_in`  in  1  1 = write, 0 = read (master `wr_out`).
- `addr_in`  in  ADDR_W  byte address (master `addr_out`).
- `data_in`  in  DATA_W  write data (master `data_out`).
- `ready`  out  1  PREADY.
- `data_out`  out  DATA_W  read data; valid while `ready`=1 on a read.
- `slverr`  out  1  PSLVERR; valid only while `ready`=1.

## Operation
- States: IDLE, ACCESS. Reset: state IDLE, `ready`=0, `slverr`=0, `data_out`=0, every register 0, wait counter 0.
- IDLE: `sel_in`=1 and `en_in`=0 (setup phase) latches `addr_in`, `wr_in` and `data_in`, loads the counter, and moves to ACCESS. `en_in`=1 without a preceding setup is ignored; the block stays in IDLE.
- Decode: offset = `addr_in` - `BASE_ADDR` (ADDR_W-bit unsigned, wrap ignored). Valid when `addr_in`[1:0]=0, `addr_in` >= `BASE_ADDR`, and offset>>2 < `NUM_REGS`. The index is offset[log2(NUM_REGS)+1:2].
- Read data is preloaded at the setup edge: `data_out` = reg[index] if valid, else 0. `data_out` holds until the next setup edge.
- ACCESS: `ready` = (counter==0) & `sel_in` & `en_in`, combinational from registered state. `slverr` = `ready` & ~valid.
- When counter≠0 it decrements each cycle. When `ready`=1, a valid write commits the latched data to reg[index] at that edge and the state returns to IDLE. An invalid write changes nothing.
- `sel_in` dropping in ACCESS before `ready`: the transfer aborts with no write, state returns to IDLE, and `slverr` is not raised.
- Bus changes to `addr_in`, `wr_in` or `data_in` during ACCESS are ignored; the latched copies are used.
- Back-to-back transfers: the master's setup cycle following completion is detected in IDLE, so there are no dead cycles beyond APB's own setup phase.
- Reset asserted mid-transfer: immediate return to reset values, and any pending write is dropped.

## Timing
- Setup edge to `ready`: 1 cycle without waits, 1+`WAIT_CYCLES` cycles with waits.
- Write visible to a following read: next transfer's setup edge (zero extra latency).
- `ready` is high for exactly one cycle per completed transfer.

## Configuration
- `APB_SLAVE_WAIT_EN` defined: the counter loads `WAIT_CYCLES`, so `ready` rises on the (`WAIT_CYCLES`+1)-th ACCESS cycle. The counter is log2(`WAIT_CYCLES`+1) bits wide. `WAIT_CYCLES`=0 is legal and behaves as zero-wait.
- Undefined: no counter logic, and `ready` is high in the first ACCESS cycle (zero-wait APB). `WAIT_CYCLES` is ignored.

## Structure
- `apb_pkg` holds the state enum (IDLE, ACCESS) and the `APB_ADDR_W`/`APB_DATA_W` defaults. The package is shared with `apb_master`.
- Sub-module `apb_slave_regfile` owns the storage: write port (we, index, data) and asynchronous read port (index→data), with async active-low clear. The top holds the FSM, decode and counter.

## Test plan
- Reset: hold `rst`=0 for 3 cycles -> `ready`=0, `slverr`=0, `data_out`=0. A subsequent read of 0x300 returns 0.
- Write 0x300 = 13, then read 0x300 -> read `data_out`=13, `slverr`=0. Zero-wait build: `ready` one cycle after each setup.
- Wait build, `WAIT_CYCLES`=2: write 0x33C = 0xDEADBEEF -> `ready` on the 3rd ACCESS cycle. A read of 0x33C returns 0xDEADBEEF.
- Errors: write 0x340 (past end), 0x302 (misaligned) and 0x2FC (below base) -> `ready`=1 and `slverr`=1 each time. All registers are unchanged; reads of those addresses give `data_out`=0 with `slverr`=1.
- Abort: with waits, write 0x304 = 5 and drop `sel_in` after the first ACCESS cycle -> no `ready`, and a read of 0x304 returns 0. `en_in`=1 issued with no setup phase gets no response.
- Back-to-back: writes to 0x308 = 1, 0x30C = 2, 0x310 = 3 with no idle between them, then reads -> 1, 2, 3. Asserting `rst` during the third write's ACCESS leaves 0x310 = 0.
